bypass_fifo_n: RTL and testbench

- Multi-entry successor to the single-entry bypass FIFO, used between guarded-atomic-action stages of the multi-cycle library.
- Parametrised in data width and depth.
- When empty, enqueued data is visible on DEQ_VALUE in the same cycle (combinational bypass); otherwise it is a circular-buffer FIFO.
- Keeps the per-phase "consumed" tracking (CONSUMED, CONSUMED_BEFORE, RESET), plus an occupancy count.

---
 rtl/bypass_fifo_n.sv | 150 +++++++++++++++
 tb/tb_bypass_fifo_n.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bypass_fifo_n.sv
// rtl/bypass_fifo_n.sv - multi-entry bypass FIFO with consumed tracking
//
// Purpose:
//   Circular-buffer FIFO of DEPTH entries of WIDTH bits. When empty, an
//   enqueued value is presented on DEQ_VALUE in the same cycle, and it can be
//   dequeued in that cycle without ever being stored. A per-phase "consumed"
//   flag records whether any enqueue happened since the last RESET strobe.
//
// Optional feature (macro BYPASS_FIFO_N_GUARD_EN):
//   Enqueue while full and dequeue while empty are dropped instead of
//   corrupting state, and either one sets the sticky ERR output.
//
// Ports:
//   CLK             in   clock, all state updates on posedge
//   RST_N           in   synchronous active-low reset
//   ENQ/ENQ_VALUE   in   enqueue strobe and data
//   NOT_FULL        out  COUNT < DEPTH
//   DEQ             in   dequeue strobe
//   DEQ_VALUE       out  head data, or ENQ_VALUE when empty
//   NOT_EMPTY       out  COUNT > 0 or ENQ
//   COUNT           out  number of stored entries (bypassed data not counted)
//   RESET           in   phase-reset strobe for consumed tracking only
//   CONSUMED        out  ENQ || consumed_q
//   CONSUMED_BEFORE out  consumed_q
//   ERR             out  sticky protocol-violation flag (guard build only)

module bypass_fifo_n #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENQ,
    input  logic [WIDTH-1:0] ENQ_VALUE,
    output logic             NOT_FULL,
    input  logic             DEQ,
    output logic [WIDTH-1:0] DEQ_VALUE,
    output logic             NOT_EMPTY,
    output logic [CW-1:0]    COUNT,
    input  logic             RESET,
    output logic             CONSUMED,
`ifdef BYPASS_FIFO_N_GUARD_EN
    output logic             ERR,
`endif
    output logic             CONSUMED_BEFORE
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          consumed_q, consumed_d;

    logic enq_ok;
    logic deq_ok;
    logic bypass;
    logic wr_en;
    logic rd_adv;

`ifdef BYPASS_FIFO_N_GUARD_EN
    logic err_q, err_d;
`endif

    always_comb begin
        enq_ok = ENQ;
        deq_ok = DEQ;
`ifdef BYPASS_FIFO_N_GUARD_EN
        // Illegal strobes are filtered here so the datapath below never sees them.
        enq_ok = ENQ && (count_q != COUNT_FULL);
        deq_ok = DEQ && ((count_q != '0) || ENQ);
        err_d  = err_q | (ENQ & ~enq_ok) | (DEQ & ~deq_ok);
`endif
        // Enqueue and dequeue while empty: the value flows straight through.
        bypass = (count_q == '0) && enq_ok && deq_ok;
        wr_en  = enq_ok && !bypass;
        rd_adv = deq_ok && !bypass;

        wr_ptr_d = wr_ptr_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (rd_adv) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
        end

        count_d = count_q;
        if (wr_en && !rd_adv) begin
            count_d = count_q + CW'(1);
        end else if (rd_adv && !wr_en) begin
            count_d = count_q - CW'(1);
        end

        // Raw ENQ is used so a dropped enqueue still counts as consumed.
        consumed_d = consumed_q;
        if (RESET) begin
            consumed_d = 1'b0;
        end else if (ENQ) begin
            consumed_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            consumed_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            consumed_q <= consumed_d;
        end
    end

`ifdef BYPASS_FIFO_N_GUARD_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ERR = err_q;
`endif

    // Storage is not reset; reset only rewinds the pointers and count.
    always_ff @(posedge CLK) begin
        if (RST_N && wr_en) begin
            mem_q[wr_ptr_q] <= ENQ_VALUE;
        end
    end

    assign DEQ_VALUE       = (count_q == '0) ? ENQ_VALUE : mem_q[rd_ptr_q];
    assign NOT_FULL        = (count_q != COUNT_FULL);
    assign NOT_EMPTY       = (count_q != '0) || ENQ;
    assign COUNT           = count_q;
    assign CONSUMED        = ENQ || consumed_q;
    assign CONSUMED_BEFORE = consumed_q;

endmodule

// File: tb/tb_bypass_fifo_n.sv
// tb/tb_bypass_fifo_n.sv - directed self-checking bench for bypass_fifo_n

module tb_bypass_fifo_n;

    logic       clk;
    logic       rst_n;
    logic       enq;
    logic [7:0] enq_value;
    logic       not_full;
    logic       deq;
    logic [7:0] deq_value;
    logic       not_empty;
    logic [2:0] count;
    logic       reset_ph;
    logic       consumed;
    logic       consumed_before;

    logic       rst3_n;
    logic       enq3;
    logic [7:0] enq_value3;
    logic       not_full3;
    logic       deq3;
    logic [7:0] deq_value3;
    logic       not_empty3;
    logic [1:0] count3;
    logic       consumed3;
    logic       consumed_before3;

`ifdef BYPASS_FIFO_N_GUARD_EN
    logic err;
    logic err3;
`endif

    int checks = 0;
    int errors = 0;

    bypass_fifo_n #(.WIDTH(8), .DEPTH(4)) u_dut (
        .CLK             (clk),
        .RST_N           (rst_n),
        .ENQ             (enq),
        .ENQ_VALUE       (enq_value),
        .NOT_FULL        (not_full),
        .DEQ             (deq),
        .DEQ_VALUE       (deq_value),
        .NOT_EMPTY       (not_empty),
        .COUNT           (count),
        .RESET           (reset_ph),
        .CONSUMED        (consumed),
`ifdef BYPASS_FIFO_N_GUARD_EN
        .ERR             (err),
`endif
        .CONSUMED_BEFORE (consumed_before)
    );

    bypass_fifo_n #(.WIDTH(8), .DEPTH(3)) u_dut3 (
        .CLK             (clk),
        .RST_N           (rst3_n),
        .ENQ             (enq3),
        .ENQ_VALUE       (enq_value3),
        .NOT_FULL        (not_full3),
        .DEQ             (deq3),
        .DEQ_VALUE       (deq_value3),
        .NOT_EMPTY       (not_empty3),
        .COUNT           (count3),
        .RESET           (1'b0),
        .CONSUMED        (consumed3),
`ifdef BYPASS_FIFO_N_GUARD_EN
        .ERR             (err3),
`endif
        .CONSUMED_BEFORE (consumed_before3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst3_n = 1'b0;
        enq = 1'b0; enq_value = '0; deq = 1'b0; reset_ph = 1'b0;
        enq3 = 1'b0; enq_value3 = '0; deq3 = 1'b0;
        tick(); tick();
        rst_n = 1'b1; rst3_n = 1'b1;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (not_full !== 1'b1) begin errors++; $display("FAIL reset_not_full got %b exp 1", not_full); end
        checks++; if (not_empty !== 1'b0) begin errors++; $display("FAIL reset_not_empty got %b exp 0", not_empty); end
        checks++; if (consumed_before !== 1'b0) begin errors++; $display("FAIL reset_consumed_before got %b exp 0", consumed_before); end
        checks++; if (count3 !== 2'd0) begin errors++; $display("FAIL reset_count3 got %0d exp 0", count3); end
        tick();
    endtask

    task automatic test_bypass();
        enq = 1'b1; enq_value = 8'hA5; deq = 1'b1;
        #1;
        checks++; if (deq_value !== 8'hA5) begin errors++; $display("FAIL bypass_value got %h exp a5", deq_value); end
        checks++; if (not_empty !== 1'b1) begin errors++; $display("FAIL bypass_not_empty got %b exp 1", not_empty); end
        tick();
        enq = 1'b0; deq = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL bypass_count got %0d exp 0", count); end
        checks++; if (not_empty !== 1'b0) begin errors++; $display("FAIL bypass_idle_not_empty got %b exp 0", not_empty); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            enq = 1'b1; enq_value = 8'(i + 1);
            tick();
        end
        enq = 1'b0;
        #1;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count); end
        checks++; if (not_full !== 1'b0) begin errors++; $display("FAIL fill_not_full got %b exp 0", not_full); end
        checks++; if (deq_value !== 8'h01) begin errors++; $display("FAIL fill_head got %h exp 01", deq_value); end
        deq = 1'b1;
        #1;
        checks++; if (not_full !== 1'b0) begin errors++; $display("FAIL full_deq_not_full got %b exp 0", not_full); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (deq_value !== 8'(i + 1)) begin
                errors++; $display("FAIL drain_value[%0d] got %h exp %h", i, deq_value, 8'(i + 1));
            end
            tick();
        end
        deq = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", count); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_seq [6];
        exp_seq[0] = 8'h10; exp_seq[1] = 8'h11; exp_seq[2] = 8'h20;
        exp_seq[3] = 8'h21; exp_seq[4] = 8'h22; exp_seq[5] = 8'h23;
        enq = 1'b1; enq_value = 8'h10; tick();
        enq_value = 8'h11; tick();
        for (int i = 0; i < 6; i++) begin
            enq = 1'b1; deq = 1'b1; enq_value = 8'h20 + 8'(i);
            #1;
            checks++;
            if (deq_value !== exp_seq[i]) begin
                errors++; $display("FAIL wrap_value[%0d] got %h exp %h", i, deq_value, exp_seq[i]);
            end
            tick();
            checks++;
            if (count !== 3'd2) begin
                errors++; $display("FAIL wrap_count[%0d] got %0d exp 2", i, count);
            end
        end
        enq = 1'b0; deq = 1'b1;
        #1;
        checks++; if (deq_value !== 8'h24) begin errors++; $display("FAIL wrap_tail0 got %h exp 24", deq_value); end
        tick();
        checks++; if (deq_value !== 8'h25) begin errors++; $display("FAIL wrap_tail1 got %h exp 25", deq_value); end
        tick();
        deq = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_final_count got %0d exp 0", count); end
    endtask

    task automatic test_consumed();
        reset_ph = 1'b1; tick();
        reset_ph = 1'b0;
        #1;
        checks++; if (consumed_before !== 1'b0) begin errors++; $display("FAIL cons_cleared got %b exp 0", consumed_before); end
        checks++; if (consumed !== 1'b0) begin errors++; $display("FAIL cons_idle got %b exp 0", consumed); end
        enq = 1'b1; enq_value = 8'h31;
        #1;
        checks++; if (consumed !== 1'b1) begin errors++; $display("FAIL cons_c1 got %b exp 1", consumed); end
        checks++; if (consumed_before !== 1'b0) begin errors++; $display("FAIL cons_before_c1 got %b exp 0", consumed_before); end
        tick();
        enq = 1'b0;
        #1;
        checks++; if (consumed_before !== 1'b1) begin errors++; $display("FAIL cons_before_c2 got %b exp 1", consumed_before); end
        checks++; if (consumed !== 1'b1) begin errors++; $display("FAIL cons_c2 got %b exp 1", consumed); end
        tick();
        reset_ph = 1'b1; enq = 1'b1; enq_value = 8'h32;
        #1;
        checks++; if (consumed !== 1'b1) begin errors++; $display("FAIL cons_c3 got %b exp 1", consumed); end
        tick();
        reset_ph = 1'b0; enq = 1'b0;
        #1;
        checks++; if (consumed_before !== 1'b0) begin errors++; $display("FAIL cons_before_c4 got %b exp 0", consumed_before); end
        checks++; if (consumed !== 1'b0) begin errors++; $display("FAIL cons_c4 got %b exp 0", consumed); end
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL cons_count got %0d exp 2", count); end
        deq = 1'b1;
        #1;
        checks++; if (deq_value !== 8'h31) begin errors++; $display("FAIL cons_drain0 got %h exp 31", deq_value); end
        tick();
        checks++; if (deq_value !== 8'h32) begin errors++; $display("FAIL cons_drain1 got %h exp 32", deq_value); end
        tick();
        deq = 1'b0;
    endtask

    task automatic test_mid_reset();
        enq3 = 1'b1; enq_value3 = 8'h55; tick();
        enq_value3 = 8'h66; tick();
        enq3 = 1'b0;
        #1;
        checks++; if (count3 !== 2'd2) begin errors++; $display("FAIL mid_pre_count got %0d exp 2", count3); end
        rst3_n = 1'b0; enq3 = 1'b1; enq_value3 = 8'h99; tick();
        rst3_n = 1'b1; enq3 = 1'b0;
        #1;
        checks++; if (count3 !== 2'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", count3); end
        checks++; if (not_empty3 !== 1'b0) begin errors++; $display("FAIL mid_not_empty got %b exp 0", not_empty3); end
        checks++; if (not_full3 !== 1'b1) begin errors++; $display("FAIL mid_not_full got %b exp 1", not_full3); end
        enq3 = 1'b1; enq_value3 = 8'h7E; tick();
        enq3 = 1'b0;
        #1;
        checks++; if (count3 !== 2'd1) begin errors++; $display("FAIL mid_enq_count got %0d exp 1", count3); end
        checks++; if (deq_value3 !== 8'h7E) begin errors++; $display("FAIL mid_value got %h exp 7e", deq_value3); end
        deq3 = 1'b1; tick();
        deq3 = 1'b0;
        #1;
        checks++; if (count3 !== 2'd0) begin errors++; $display("FAIL mid_deq_count got %0d exp 0", count3); end
        for (int i = 0; i < 3; i++) begin
            enq3 = 1'b1; enq_value3 = 8'hA1 + 8'(i); tick();
        end
        enq3 = 1'b0;
        #1;
        checks++; if (count3 !== 2'd3) begin errors++; $display("FAIL d3_full_count got %0d exp 3", count3); end
        checks++; if (not_full3 !== 1'b0) begin errors++; $display("FAIL d3_not_full got %b exp 0", not_full3); end
        deq3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (deq_value3 !== 8'hA1 + 8'(i)) begin
                errors++; $display("FAIL d3_drain[%0d] got %h exp %h", i, deq_value3, 8'hA1 + 8'(i));
            end
            tick();
        end
        deq3 = 1'b0;
        #1;
        checks++; if (count3 !== 2'd0) begin errors++; $display("FAIL d3_final_count got %0d exp 0", count3); end
    endtask

`ifdef BYPASS_FIFO_N_GUARD_EN
    task automatic test_guard();
        for (int i = 0; i < 4; i++) begin
            enq = 1'b1; enq_value = 8'(i + 1); tick();
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL guard_err_pre got %b exp 0", err); end
        enq = 1'b1; enq_value = 8'hEE; tick();
        enq = 1'b0;
        #1;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL guard_count got %0d exp 4", count); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL guard_err got %b exp 1", err); end
        deq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (deq_value !== 8'(i + 1)) begin
                errors++; $display("FAIL guard_drain[%0d] got %h exp %h", i, deq_value, 8'(i + 1));
            end
            tick();
        end
        deq = 1'b0;
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL guard_err_sticky got %b exp 1", err); end
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL guard_err_reset got %b exp 0", err); end
    endtask
`endif

    initial begin
        test_reset();
        test_bypass();
        test_fill_drain();
        test_wrap();
        test_consumed();
        test_mid_reset();
`ifdef BYPASS_FIFO_N_GUARD_EN
        test_guard();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
